// File: rtl/phys_bypass_scoreboard.sv
// -----------------------------------------------------------------------------
// phys_bypass_scoreboard
//
// Physical-register readiness scoreboard and operand bypass selector, placed
// between rename/issue and the EX operand muxes. It keeps one busy bit per
// physical tag and picks a forwarding source for each issuing operand. It
// raises issue_stall when an operand is neither in the PRF nor forwardable.
// A small stall monitor flags a pipeline stuck in stall for STALL_TIMEOUT
// consecutive cycles.
//
// Optional feature macro: BYPASS_PERF_CNT_EN adds the fwd_cnt and stall_cyc
// performance counters.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   alloc_valid/tag rename allocates a destination (sets busy)
//   wb_valid/tag    PRF write (clears busy, also forwardable this cycle)
//   flush           clears every busy bit
//   byp_valid/tag/is_load  in-flight stages, index 0 youngest
//   src_valid/tag   issuing instruction's source operands
//   fwd_sel         per source: 0 PRF, k+1 stage k, NUM_BYP+1 writeback port
//   issue_stall     some valid source is unavailable
//   stall_timeout   sticky stuck-pipeline flag
//   fwd_cnt, stall_cyc  (BYPASS_PERF_CNT_EN only) performance counters
// -----------------------------------------------------------------------------
module phys_bypass_scoreboard #(
   parameter int PHYS_REGS     = 64,
   parameter int TAG_W         = $clog2(PHYS_REGS),
   parameter int NUM_SRC       = 2,
   parameter int NUM_BYP       = 2,
   parameter int STALL_TIMEOUT = 256,
   parameter int SEL_W         = $clog2(NUM_BYP + 2)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_valid,
   input  logic [TAG_W-1:0]           alloc_tag,
   input  logic                       wb_valid,
   input  logic [TAG_W-1:0]           wb_tag,
   input  logic                       flush,
   input  logic [NUM_BYP-1:0]         byp_valid,
   input  logic [NUM_BYP*TAG_W-1:0]   byp_tag,
   input  logic [NUM_BYP-1:0]         byp_is_load,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic                       issue_stall,
   output logic                       stall_timeout
`ifdef BYPASS_PERF_CNT_EN
   ,
   output logic [31:0]                fwd_cnt,
   output logic [31:0]                stall_cyc
`endif
);

   localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_STALLING = 1'b1;

   logic [PHYS_REGS-1:0] busy;
   logic [NUM_SRC-1:0]   unavail;
   logic [0:0]           state;
   logic [CNT_W-1:0]     stall_cnt;

   // ---------------------------------------------------------------------------
   // Busy table. Flush beats alloc; within a normal cycle the alloc write comes
   // after the wb clear so a same-tag alloc+wb leaves the bit set.
   // ---------------------------------------------------------------------------
   // NOTE: the busy table is a flop vector, not a RAM, so it can and must be
   // cleared by the asynchronous reset; non-blocking assignments keep the
   // ordered read-modify-write of individual bits race-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         if (wb_valid)
            busy[wb_tag] <= 1'b0;
         if (alloc_valid && (alloc_tag != '0))
            busy[alloc_tag] <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-source forwarding select. Stages are scanned oldest to youngest so
   // the youngest matching stage is the one that sticks.
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block is given a default before the loop, so
   // no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      logic [TAG_W-1:0] s_tag;
      logic             hit;
      logic             hit_load;
      logic [SEL_W-1:0] hit_sel;
      fwd_sel  = '0;
      unavail  = '0;
      s_tag    = '0;
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_sel  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         s_tag    = src_tag[i*TAG_W +: TAG_W];
         hit      = 1'b0;
         hit_load = 1'b0;
         hit_sel  = '0;
         for (int k = NUM_BYP - 1; k >= 0; k--) begin
            if (byp_valid[k] && (byp_tag[k*TAG_W +: TAG_W] == s_tag)) begin
               hit      = 1'b1;
               hit_load = byp_is_load[k];
               hit_sel  = SEL_W'(k + 1);
            end
         end
         if (!src_valid[i] || (s_tag == '0)) begin
            fwd_sel[i*SEL_W +: SEL_W] = '0;
         end else if (hit) begin
            // A load still in flight shadows any older stage with the same tag.
            if (hit_load)
               unavail[i] = 1'b1;
            else
               fwd_sel[i*SEL_W +: SEL_W] = hit_sel;
         end else if (wb_valid && (wb_tag == s_tag)) begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(NUM_BYP + 1);
         end else if (busy[s_tag]) begin
            unavail[i] = 1'b1;
         end
      end
   end

   assign issue_stall = |unavail;

   // ---------------------------------------------------------------------------
   // Stall monitor. stall_cnt saturates at STALL_TIMEOUT; the flag is sticky
   // until reset and rises on the edge where the count reaches the limit.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         stall_cnt     <= '0;
         stall_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue_stall) begin
                  state     <= S_STALLING;
                  stall_cnt <= CNT_W'(1);
               end
            end
            default: begin
               if (!issue_stall || flush) begin
                  state     <= S_IDLE;
                  stall_cnt <= '0;
               end else if (stall_cnt != CNT_MAX) begin
                  stall_cnt <= stall_cnt + CNT_W'(1);
                  if (stall_cnt + CNT_W'(1) == CNT_MAX)
                     stall_timeout <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef BYPASS_PERF_CNT_EN
   logic [31:0] fwd_inc;

   always_comb begin
      fwd_inc = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (fwd_sel[i*SEL_W +: SEL_W] != '0)
            fwd_inc = fwd_inc + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_cnt   <= '0;
         stall_cyc <= '0;
      end else begin
         fwd_cnt <= fwd_cnt + fwd_inc;
         if (issue_stall)
            stall_cyc <= stall_cyc + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_phys_bypass_scoreboard.sv
// -----------------------------------------------------------------------------
// Self-checking bench for phys_bypass_scoreboard (STALL_TIMEOUT = 4).
// Each step drives inputs just after a falling edge, pushes the expected
// fwd_sel / issue_stall pair to a queue, and pops and compares it once the
// combinational outputs have settled, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_phys_bypass_scoreboard;

   localparam int PHYS_REGS     = 64;
   localparam int TAG_W         = 6;
   localparam int NUM_SRC       = 2;
   localparam int NUM_BYP       = 2;
   localparam int STALL_TIMEOUT = 4;
   localparam int SEL_W         = 2;

   typedef struct {
      string            name;
      logic [NUM_SRC*SEL_W-1:0] sel;
      logic             stall;
   } exp_t;

   logic                     clk;
   logic                     rst;
   logic                     alloc_valid;
   logic [TAG_W-1:0]         alloc_tag;
   logic                     wb_valid;
   logic [TAG_W-1:0]         wb_tag;
   logic                     flush;
   logic [NUM_BYP-1:0]       byp_valid;
   logic [NUM_BYP*TAG_W-1:0] byp_tag;
   logic [NUM_BYP-1:0]       byp_is_load;
   logic [NUM_SRC-1:0]       src_valid;
   logic [NUM_SRC*TAG_W-1:0] src_tag;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic                     issue_stall;
   logic                     stall_timeout;
`ifdef BYPASS_PERF_CNT_EN
   logic [31:0]              fwd_cnt;
   logic [31:0]              stall_cyc;
`endif

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   phys_bypass_scoreboard #(
      .PHYS_REGS    (PHYS_REGS),
      .TAG_W        (TAG_W),
      .NUM_SRC      (NUM_SRC),
      .NUM_BYP      (NUM_BYP),
      .STALL_TIMEOUT(STALL_TIMEOUT),
      .SEL_W        (SEL_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_tag    (alloc_tag),
      .wb_valid     (wb_valid),
      .wb_tag       (wb_tag),
      .flush        (flush),
      .byp_valid    (byp_valid),
      .byp_tag      (byp_tag),
      .byp_is_load  (byp_is_load),
      .src_valid    (src_valid),
      .src_tag      (src_tag),
      .fwd_sel      (fwd_sel),
      .issue_stall  (issue_stall),
      .stall_timeout(stall_timeout)
`ifdef BYPASS_PERF_CNT_EN
      ,
      .fwd_cnt      (fwd_cnt),
      .stall_cyc    (stall_cyc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      alloc_valid = 1'b0;
      alloc_tag   = '0;
      wb_valid    = 1'b0;
      wb_tag      = '0;
      flush       = 1'b0;
      byp_valid   = '0;
      byp_tag     = '0;
      byp_is_load = '0;
      src_valid   = '0;
      src_tag     = '0;
   endtask

   task automatic push(input string name, input logic [NUM_SRC*SEL_W-1:0] sel, input logic stall);
      exp_t e;
      e.name  = name;
      e.sel   = sel;
      e.stall = stall;
      exp_q.push_back(e);
   endtask

   // Let the combinational outputs settle, then compare against the oldest
   // pending expectation.
   task automatic observe();
      exp_t e;
      #2;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({e.name, "_sel"}, 32'(fwd_sel), 32'(e.sel));
         check({e.name, "_stall"}, 32'(issue_stall), 32'(e.stall));
      end
   endtask

   // One cycle: expect, observe, then advance to the next falling edge.
   task automatic step(input string name, input logic [NUM_SRC*SEL_W-1:0] sel, input logic stall);
      push(name, sel, stall);
      observe();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      push("reset", '0, 1'b0);
      observe();
      check("reset_timeout", 32'(stall_timeout), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Zero tag and an idle tag never stall, and idling never times out.
      src_valid = 2'b11;
      src_tag   = {6'd5, 6'd0};
      step("zero_tag", 4'b0000, 1'b0);
      clear_inputs();
      repeat (STALL_TIMEOUT + 2) step("idle", 4'b0000, 1'b0);
      check("idle_timeout", 32'(stall_timeout), 32'd0);

      // Busy tag stalls until a non-load bypass stage covers it.
      alloc_valid = 1'b1;
      alloc_tag   = 6'd7;
      step("alloc7", 4'b0000, 1'b0);
      clear_inputs();
      src_valid = 2'b01;
      src_tag   = {6'd0, 6'd7};
      step("busy7", 4'b0000, 1'b1);
      byp_valid = 2'b01;
      byp_tag   = {6'd0, 6'd7};
      step("byp0_7", 4'b0001, 1'b0);

      // Youngest-stage priority, including load shadowing.
      clear_inputs();
      src_valid = 2'b01;
      src_tag   = {6'd0, 6'd9};
      byp_valid = 2'b11;
      byp_tag   = {6'd9, 6'd9};
      step("youngest", 4'b0001, 1'b0);
      byp_is_load = 2'b01;
      step("load_young", 4'b0000, 1'b1);
      byp_is_load = 2'b10;
      step("load_old", 4'b0001, 1'b0);
      byp_is_load = 2'b00;
      byp_valid   = 2'b10;
      step("byp1_only", 4'b0010, 1'b0);

      // Same-cycle writeback is forwarded; the bit is clear the cycle after.
      clear_inputs();
      alloc_valid = 1'b1;
      alloc_tag   = 6'd12;
      step("alloc12", 4'b0000, 1'b0);
      clear_inputs();
      wb_valid  = 1'b1;
      wb_tag    = 6'd12;
      src_valid = 2'b11;
      src_tag   = {6'd12, 6'd12};
      step("wb_port", 4'b1111, 1'b0);
      wb_valid = 1'b0;
      step("after_wb", 4'b0000, 1'b0);

      // Alloc beats wb on the same tag; flush beats alloc.
      clear_inputs();
      alloc_valid = 1'b1;
      alloc_tag   = 6'd20;
      wb_valid    = 1'b1;
      wb_tag      = 6'd20;
      step("alloc_wb20", 4'b0000, 1'b0);
      clear_inputs();
      src_valid = 2'b01;
      src_tag   = {6'd0, 6'd20};
      step("alloc_wins", 4'b0000, 1'b1);
      clear_inputs();
      flush       = 1'b1;
      alloc_valid = 1'b1;
      alloc_tag   = 6'd21;
      step("flush", 4'b0000, 1'b0);
      clear_inputs();
      src_valid = 2'b11;
      src_tag   = {6'd21, 6'd20};
      step("post_flush", 4'b0000, 1'b0);

      // Fresh reset, then hold an unresolved stall into timeout.
      clear_inputs();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      alloc_valid = 1'b1;
      alloc_tag   = 6'd30;
      step("alloc30", 4'b0000, 1'b0);
      clear_inputs();
      src_valid = 2'b01;
      src_tag   = {6'd0, 6'd30};
      for (int n = 0; n < STALL_TIMEOUT; n++) begin
         check("timeout_early", 32'(stall_timeout), 32'd0);
         step("hold30", 4'b0000, 1'b1);
      end
      check("timeout_set", 32'(stall_timeout), 32'd1);
`ifdef BYPASS_PERF_CNT_EN
      check("stall_cyc", stall_cyc, 32'd4);
      check("fwd_cnt", fwd_cnt, 32'd0);
`endif
      src_valid = 2'b00;
      step("resolved", 4'b0000, 1'b0);
      step("resolved2", 4'b0000, 1'b0);
      check("timeout_sticky", 32'(stall_timeout), 32'd1);

      // Asynchronous reset mid-stall clears the flag and the busy table at once.
      src_valid = 2'b01;
      #2;
      check("pre_rst_stall", 32'(issue_stall), 32'd1);
      rst = 1'b1;
      #1;
      check("async_timeout", 32'(stall_timeout), 32'd0);
      check("async_busy", 32'(issue_stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/phys_bypass_scoreboard.md
# phys_bypass_scoreboard

Parametrised physical-register readiness scoreboard and bypass selector for the renamed pipeline. It tracks a busy bit for every physical tag, selects per-source forwarding from any of NUM_BYP in-flight stages or the writeback port, and raises an issue stall when an operand is neither in the PRF nor forwardable (load-use included). It sits between rename/issue and the EX operand muxes. A sequential stall monitor counts consecutive stall cycles and flags a stuck pipeline.

## Interface
Parameters:
- PHYS_REGS, 64, number of physical registers; tag 0 is the hardwired zero register.
- TAG_W, $clog2(PHYS_REGS), physical tag width.
- NUM_SRC, 2, source operands checked per cycle.
- NUM_BYP, 2, bypass stages; index 0 is the youngest (EX/MEM).
- STALL_TIMEOUT, 256, consecutive stall cycles before timeout; must be ≥2.
- SEL_W, $clog2(NUM_BYP+2), width of one forward-select field (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alloc_valid  in  1  rename allocates a new destination this cycle.
- alloc_tag  in  TAG_W  newly allocated destination tag.
- wb_valid  in  1  PRF write this cycle.
- wb_tag  in  TAG_W  PRF write tag.
- flush  in  1  squash; clears all busy bits.
- byp_valid  in  NUM_BYP  stage k holds a register-writing instruction.
- byp_tag  in  NUM_BYP*TAG_W  destination tag of stage k (field k at bits k*TAG_W).
- byp_is_load  in  NUM_BYP  stage k result is not yet available (load in flight).
- src_valid  in  NUM_SRC  source i is used by the issuing instruction.
- src_tag  in  NUM_SRC*TAG_W  physical tag of source i.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = PRF, k+1 = bypass stage k, NUM_BYP+1 = writeback port.
- issue_stall  out  1  at least one valid source is unavailable.
- stall_timeout  out  1  sticky stuck-pipeline flag.

## Operation
- Busy table: PHYS_REGS bits, all 0 at reset. Bit 0 is never set.
- alloc_valid with alloc_tag≠0 sets busy[alloc_tag]. wb_valid clears busy[wb_tag].
- When alloc and wb hit the same tag in the same cycle, alloc wins: the bit ends set.
- flush clears every bit and overrides same-cycle alloc.
- Per source i, the selection is combinational and priority-ordered:
  - Tag 0 or !src_valid → sel 0, never stalls.
  - The lowest k with byp_valid[k] and byp_tag[k]==src_tag hits. If byp_is_load[k] is set, the source is unavailable. Otherwise sel = k+1. Younger stages always override older ones.
  - Otherwise, wb_valid and wb_tag==src_tag → sel NUM_BYP+1.
  - Otherwise, busy[src_tag]==0 → sel 0. busy==1 → unavailable, sel 0.
- issue_stall = OR over sources of "unavailable".
- Stall monitor FSM, states IDLE and STALLING:
  - IDLE→STALLING when issue_stall is asserted, with stall_cnt loaded to 1.
  - In STALLING, stall_cnt increments by 1 per cycle while issue_stall is high and saturates at STALL_TIMEOUT.
  - STALLING→IDLE when issue_stall is deasserted or flush is asserted. stall_cnt clears to 0.
  - When stall_cnt reaches STALL_TIMEOUT, stall_timeout sets and stays set until rst.
  - stall_cnt is $clog2(STALL_TIMEOUT+1) bits wide.

## Timing
- Reset values: busy all 0, FSM IDLE, stall_cnt 0, stall_timeout 0. With all inputs at 0, fwd_sel is 0 and issue_stall is 0.
- fwd_sel and issue_stall are combinational with 0-cycle latency. They reflect the busy state from before the current edge plus the current byp and wb inputs.
- Busy updates from alloc, wb and flush are visible to sources on the cycle after the edge. A same-cycle writeback is covered by the wb-port bypass.
- stall_timeout rises on the edge where stall_cnt becomes STALL_TIMEOUT, i.e. after STALL_TIMEOUT consecutive stall cycles.
- rst asserted mid-stall: stall_cnt, FSM, busy and stall_timeout clear immediately (asynchronous).

## Configuration
- BYPASS_PERF_CNT_EN defined: adds two outputs, fwd_cnt (32 bits) and stall_cyc (32 bits), both reset to 0.
  - fwd_cnt increments by the number of sources with a nonzero sel each cycle.
  - stall_cyc increments on every cycle with issue_stall high.
  - Both wrap modulo 2^32.
- BYPASS_PERF_CNT_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then src_valid=2'b11, src_tag={p5,p0} → fwd_sel all 0, issue_stall 0. After STALL_TIMEOUT idle cycles, stall_timeout stays 0.
- alloc p7, next cycle src0=p7 with no bypass hit → issue_stall 1. Then byp_valid[0]=1, byp_tag[0]=p7 → sel0=1, stall 0.
- byp0 and byp1 both tag p9, byp_is_load=2'b00 → sel=1 (youngest stage). byp_is_load[0]=1 → issue_stall 1 even though stage 1 also matches.
- busy p12, wb_valid p12 with src0=p12 in the same cycle → sel0=NUM_BYP+1 (3), no stall. The following cycle, src0=p12 gives sel 0.
- alloc and wb of p20 in the same cycle → busy[p20]=1 afterwards. Then flush → busy cleared and src p20 gives sel 0, no stall.
- Hold a busy source unresolved with STALL_TIMEOUT=4 → stall_timeout rises after the 4th stall cycle. It stays high after the stall resolves and clears only on rst. With BYPASS_PERF_CNT_EN, stall_cyc=4 at that point.
